// File: rtl/csa_accum_seq.sv
// Carry-save accumulate-and-resolve sequencer: compresses a stream of operands 3:2, then resolves S/C into a binary sum.
// Optional overflow output enabled by defining CSA_OVF_DETECT_EN.
module csa_accum_seq #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             busy
`ifdef CSA_OVF_DETECT_EN
  ,
  output logic             out_ovf
`endif
);

  // SETTLE is one alignment cycle between the last beat and the first carry step,
  // which puts out_valid two edges after the last accept at the earliest.
  typedef enum logic [1:0] {ACCUM, SETTLE, RESOLVE, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] s, c;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] maj, half;
  logic             accept;

  assign accept    = in_valid & in_ready;
  assign maj       = (s & c) | (s & in_data) | (c & in_data);
  assign half      = s & c;
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign busy      = (state != ACCUM);

  always_comb begin
    state_next = state;
    case (state)
      ACCUM:   if (accept && in_last) state_next = SETTLE;
      SETTLE:  state_next = RESOLVE;
      RESOLVE: if (c == '0) state_next = DONE;
      DONE:    if (out_ready) state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ACCUM;
    else          state <= state_next;
  end

`ifdef CSA_OVF_DETECT_EN
  logic ovf;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s         <= '0;
      c         <= '0;
      cnt       <= '0;
      out_sum   <= '0;
      out_count <= '0;
`ifdef CSA_OVF_DETECT_EN
      ovf       <= 1'b0;
      out_ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            s <= s ^ c ^ in_data;
            c <= maj << 1;
            if (cnt != '1) cnt <= cnt + 1'b1;
`ifdef CSA_OVF_DETECT_EN
            ovf <= ovf | maj[WIDTH-1];
`endif
          end
        end
        RESOLVE: begin
          if (c != '0) begin
            s <= s ^ c;
            c <= half << 1;
`ifdef CSA_OVF_DETECT_EN
            ovf <= ovf | half[WIDTH-1];
`endif
          end else begin
            out_sum   <= s;
            out_count <= cnt;
`ifdef CSA_OVF_DETECT_EN
            out_ovf   <= ovf;
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            s   <= '0;
            c   <= '0;
            cnt <= '0;
`ifdef CSA_OVF_DETECT_EN
            ovf <= 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_accum_seq.sv
// Self-checking bench for csa_accum_seq: wide-integer reference model plus directed literal cases.
module tb_csa_accum_seq;
  localparam int WIDTH = 64;
  localparam int CNT_W = 8;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             in_valid, in_ready, in_last;
  logic [WIDTH-1:0] in_data;
  logic             out_valid, out_ready, busy;
  logic [WIDTH-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             ovf_w;

  csa_accum_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .busy      (busy)
`ifdef CSA_OVF_DETECT_EN
    ,
    .out_ovf   (ovf_w)
`endif
  );
`ifndef CSA_OVF_DETECT_EN
  assign ovf_w = 1'b0;
`endif

  always #5 clock = ~clock;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
  } exp_t;

  exp_t        expq[$];
  logic [95:0] m_sum;
  logic [CNT_W-1:0] m_cnt;
  int          total = 0;
  int          bad = 0;
  int          rdy_mode = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, want);
    end
  endtask

  task automatic model_clear();
    m_sum = '0;
    m_cnt = '0;
  endtask

  // Result checker: every cycle a result is presented it must match the oldest expected one.
  always @(negedge clock) begin
    if (reset_n === 1'b1 && out_valid === 1'b1) begin
      if (expq.size() == 0) begin
        chk("unexpected_valid", {95'd0, out_valid}, 96'd0);
      end else begin
        chk("out_sum", out_sum, expq[0].sum);
        chk("out_count", out_count, expq[0].cnt);
`ifdef CSA_OVF_DETECT_EN
        chk("out_ovf", ovf_w, expq[0].ovf);
`endif
        chk("in_ready_in_done", in_ready, 1'b0);
        if (out_ready) void'(expq.pop_front());
      end
    end
  end

  always @(posedge clock) begin
    #1;
    if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic send_beat(input logic [WIDTH-1:0] d, input logic last);
    logic acc;
    exp_t e;
    acc = 1'b0;
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    for (int i = 0; i < 400 && !acc; i++) begin
      @(negedge clock);
      acc = in_ready;
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'($urandom);
    in_data  = {$urandom, $urandom};
    if (!acc) begin
      chk("accept_timeout", {95'd0, acc}, 96'd1);
    end else begin
      m_sum = m_sum + {32'd0, d};
      if (m_cnt != '1) m_cnt = m_cnt + 1'b1;
      if (last) begin
        e.sum = m_sum[WIDTH-1:0];
        e.cnt = m_cnt;
        e.ovf = (m_sum[95:WIDTH] != '0);
        expq.push_back(e);
        model_clear();
      end
    end
  endtask

  // Returns how many edges after the last accept edge out_valid first appears.
  task automatic wait_valid(output int lat);
    logic found;
    found = 1'b0;
    lat = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clock);
      if (out_valid) begin
        found = 1'b1;
      end else begin
        chk("in_ready_while_busy", in_ready, 1'b0);
        chk("busy_while_resolving", busy, 1'b1);
        lat++;
      end
    end
    chk("valid_timeout", {95'd0, found}, 96'd1);
  endtask

  task automatic consume();
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    @(negedge clock);
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    chk("in_ready_after_hs", in_ready, 1'b1);
    chk("out_valid_after_hs", out_valid, 1'b0);
    chk("busy_after_hs", busy, 1'b0);
  endtask

  task automatic check_result(input string name, input int lat_want, input logic [WIDTH-1:0] sum,
                              input logic [CNT_W-1:0] cnt, input logic ovf);
    int lat;
    wait_valid(lat);
    if (lat_want >= 0) chk({name, "_latency"}, lat, lat_want);
    chk({name, "_sum"}, out_sum, sum);
    chk({name, "_count"}, out_count, cnt);
    chk({name, "_busy"}, busy, 1'b1);
`ifdef CSA_OVF_DETECT_EN
    chk({name, "_ovf"}, ovf_w, ovf);
`endif
    consume();
  endtask

  task automatic reset_checks(input string name);
    chk({name, "_in_ready"}, in_ready, 1'b1);
    chk({name, "_out_valid"}, out_valid, 1'b0);
    chk({name, "_out_sum"}, out_sum, 96'd0);
    chk({name, "_out_count"}, out_count, 96'd0);
    chk({name, "_busy"}, busy, 1'b0);
`ifdef CSA_OVF_DETECT_EN
    chk({name, "_out_ovf"}, ovf_w, 1'b0);
`endif
  endtask

  initial begin
    int lat;
    logic [WIDTH-1:0] d;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    model_clear();
    #22;
    reset_checks("reset");
    #6 reset_n = 1'b1;
    @(posedge clock);
    #1;

    send_beat(64'h1234, 1'b1);
    check_result("single", 2, 64'h1234, 8'd1, 1'b0);

    send_beat(64'd1, 1'b0);
    send_beat(64'd2, 1'b0);
    send_beat(64'd3, 1'b1);
    check_result("one_two_three", 3, 64'd6, 8'd3, 1'b0);

    send_beat('1, 1'b0);
    send_beat(64'd1, 1'b1);
    wait_valid(lat);
    chk("wrap_latency", lat, 65);
    chk("wrap_latency_bound", {95'd0, lat <= WIDTH + 2}, 96'd1);
    chk("wrap_sum", out_sum, 96'd0);
    chk("wrap_count", out_count, 96'd2);
`ifdef CSA_OVF_DETECT_EN
    chk("wrap_ovf", ovf_w, 1'b1);
`endif
    consume();

    send_beat(64'd1, 1'b0);
    send_beat(64'd2, 1'b0);
    send_beat(64'd3, 1'b1);
    wait_valid(lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_sum", out_sum, 96'd6);
    end
    consume();
    send_beat(64'd5, 1'b1);
    check_result("after_hold", 2, 64'd5, 8'd1, 1'b0);

    send_beat(64'hFF, 1'b0);
    send_beat(64'h01, 1'b1);
    @(negedge clock);
    @(negedge clock);
    chk("busy_before_reset", busy, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    reset_checks("mid_resolve_reset");
    expq.delete();
    model_clear();
    #5 reset_n = 1'b1;
    @(posedge clock);
    #1;
    send_beat(64'd7, 1'b1);
    check_result("post_reset", 2, 64'd7, 8'd1, 1'b0);

    for (int i = 0; i < 300; i++) send_beat(64'd1, 1'b0);
    send_beat(64'd1, 1'b1);
    check_result("saturate", -1, 64'd301, 8'd255, 1'b0);

    rdy_mode = 1;
    for (int s = 0; s < 40; s++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clock);
          #1;
        end
        case ($urandom_range(0, 3))
          0:       d = '1;
          1:       d = 64'($urandom_range(0, 255));
          default: d = {$urandom, $urandom};
        endcase
        send_beat(d, b == len - 1);
      end
    end
    for (int i = 0; i < 500 && expq.size() != 0; i++) @(posedge clock);
    chk("drain", expq.size(), 96'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
